// File: rtl/noc_pkg.sv
// Shared types and flit field positions for the NoC injection path.
// Flits are 64 bits; bit 63 marks a head flit and bit 62 marks a tail flit.
package noc_pkg;

    localparam int FLIT_W   = 64;
    localparam int HEAD_BIT = 63;
    localparam int TAIL_BIT = 62;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic is_head(input flit_t f);
        return f[HEAD_BIT];
    endfunction

    function automatic logic is_tail(input flit_t f);
        return f[TAIL_BIT];
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Two-entry flit FIFO that registers the router-facing side of the injection port.
// The head entry is read straight from storage, so it stays stable while it waits to be popped.
module noc_flit_fifo
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       push,
    input  flit_t      push_data,
    input  logic       pop,
    output flit_t      pop_data,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    flit_t      mem_reg [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign full     = (count_reg == 2'd2);
    assign empty    = (count_reg == 2'd0);
    assign count    = count_reg;
    assign pop_data = mem_reg[rd_ptr_reg];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one router injection port among N_REQ requesters.
// A granted head flit locks the port to its owner until that owner's tail flit is accepted.
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*FLIT_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [FLIT_W-1:0]       out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    lock_o,
    output logic [IDX_W-1:0]        lock_idx_o,
    output logic                    err_o
);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    arb_state_e       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] lock_idx_reg, lock_idx_next;
    logic             err_reg, err_next;

    flit_t            req_flit [N_REQ];
    logic [N_REQ-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] drop_idx;
    logic             space;
    logic             push;
    flit_t            push_data;
    logic [N_REQ-1:0] ready_comb;

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    flit_t      fifo_data;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_flit[gi] = req_data_i[gi*FLIT_W +: FLIT_W];
            assign cand[gi]     = req_valid_i[gi] & is_head(req_flit[gi]);
        end
    endgenerate

    // Space depends only on the registered fill level, keeping the router's ready off this path.
    assign space = (fifo_count < 2'd2);

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        drop_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int idx;
            idx = (int'(ptr_reg) + off) % N_REQ;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                drop_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        lock_idx_next = lock_idx_reg;
        err_next      = err_reg;
        ready_comb    = '0;
        push          = 1'b0;
        push_data     = req_flit[winner];
        case (state_reg)
            ARB_IDLE: begin
                if (found) begin
                    ready_comb[winner] = space;
                    if (space) begin
                        push = 1'b1;
                        if (is_tail(req_flit[winner])) begin
                            ptr_next = next_idx(winner);
                        end else begin
                            state_next    = ARB_LOCKED;
                            lock_idx_next = winner;
                        end
                    end
                end else if (|req_valid_i) begin
                    // Headless flit outside a packet: swallow it and flag the error.
                    ready_comb[drop_idx] = space;
                    if (space) begin
                        err_next = 1'b1;
                    end
                end
            end
            ARB_LOCKED: begin
                ready_comb[lock_idx_reg] = space;
                push_data                = req_flit[lock_idx_reg];
                if (req_valid_i[lock_idx_reg] && space) begin
                    push = 1'b1;
                    if (is_head(req_flit[lock_idx_reg])) begin
                        err_next = 1'b1;
                    end
                    if (is_tail(req_flit[lock_idx_reg])) begin
                        state_next    = ARB_IDLE;
                        ptr_next      = next_idx(lock_idx_reg);
                        lock_idx_next = '0;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            ptr_reg      <= '0;
            lock_idx_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            lock_idx_reg <= lock_idx_next;
            err_reg      <= err_next;
        end
    end

    noc_flit_fifo u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (push && !fifo_full),
        .push_data (push_data),
        .pop       (out_valid_o && out_ready_i),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign req_ready_o = rst ? '0 : ready_comb;
    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_data;
    assign lock_o      = (state_reg == ARB_LOCKED);
    assign lock_idx_o  = lock_idx_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: a vector table for reset, grants, contention and
// protocol errors, plus hand sequences for backpressure and reset in the middle of a packet.
module tb_noc_inject_arbiter;

    logic         clk;
    logic         rst;
    logic [63:0]  d [4];
    logic [255:0] req_data;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         lock;
    logic [1:0]   lock_idx;
    logic         err;

    int total = 0;
    int bad   = 0;

    assign req_data = {d[3], d[2], d[1], d[0]};

    noc_inject_arbiter #(.N_REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .lock_o      (lock),
        .lock_idx_o  (lock_idx),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [63:0] d [4];
        logic        ordy;
        logic [3:0]  e_ready;
        logic        e_ov;
        logic [63:0] e_od;
        logic        e_lock;
        logic [1:0]  e_lidx;
        logic        e_err;
    } vec_t;

    vec_t tbl [$];

    task automatic row(input logic r, input logic [3:0] v,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] d3,
                       input logic o, input logic [3:0] er, input logic eov,
                       input logic [63:0] eod, input logic el, input logic [1:0] eli,
                       input logic ee);
        vec_t x;
        x.rst = r; x.valid = v; x.d[0] = d0; x.d[1] = d1; x.d[2] = d2; x.d[3] = d3;
        x.ordy = o; x.e_ready = er; x.e_ov = eov; x.e_od = eod;
        x.e_lock = el; x.e_lidx = eli; x.e_err = ee;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] d3, input logic o);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        out_ready = o;
        #2;
    endtask

    localparam logic [63:0] Z = 64'h0;

    logic [63:0] bp [4];
    int acc;
    int got;
    int cyc;

    initial begin
        rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
        d[0] = 64'hC000_0000_0000_00F0; d[1] = d[0]; d[2] = d[0]; d[3] = d[0];

        // reset with every requester valid
        row(1, 4'hF, d[0], d[0], d[0], d[0], 1, 4'h0, 0, Z, 0, 0, 0);
        row(1, 4'hF, d[0], d[0], d[0], d[0], 1, 4'h0, 0, Z, 0, 0, 0);
        // single-flit packet from req1, then ptr=2 picks req2, then req3, wrap to 0
        row(0, 4'h2, Z, 64'hC000_0000_0000_0001, Z, Z, 1, 4'h2, 0, Z, 0, 0, 0);
        row(0, 4'h0, Z, Z, Z, Z, 1, 4'h0, 1, 64'hC000_0000_0000_0001, 0, 0, 0);
        row(0, 4'hF, 64'hC000_0000_0000_00A0, 64'hC000_0000_0000_00A1,
            64'hC000_0000_0000_00A2, 64'hC000_0000_0000_00A3, 1, 4'h4, 0, Z, 0, 0, 0);
        row(0, 4'hF, 64'hC000_0000_0000_00A0, 64'hC000_0000_0000_00A1,
            64'hC000_0000_0000_00A2, 64'hC000_0000_0000_00A3, 1, 4'h8, 1,
            64'hC000_0000_0000_00A2, 0, 0, 0);
        row(0, 4'h0, Z, Z, Z, Z, 1, 4'h0, 1, 64'hC000_0000_0000_00A3, 0, 0, 0);
        // contention: req0 and req2 three-flit packets, ptr=0
        row(0, 4'h5, 64'h8000_0000_0000_0010, Z, 64'h8000_0000_0000_0020, Z, 1,
            4'h1, 0, Z, 0, 0, 0);
        row(0, 4'h5, 64'h0000_0000_0000_0011, Z, 64'h8000_0000_0000_0020, Z, 1,
            4'h1, 1, 64'h8000_0000_0000_0010, 1, 0, 0);
        row(0, 4'h5, 64'h4000_0000_0000_0012, Z, 64'h8000_0000_0000_0020, Z, 1,
            4'h1, 1, 64'h0000_0000_0000_0011, 1, 0, 0);
        row(0, 4'h4, Z, Z, 64'h8000_0000_0000_0020, Z, 1,
            4'h4, 1, 64'h4000_0000_0000_0012, 0, 0, 0);
        row(0, 4'h4, Z, Z, 64'h0000_0000_0000_0021, Z, 1,
            4'h4, 1, 64'h8000_0000_0000_0020, 1, 2, 0);
        row(0, 4'h4, Z, Z, 64'h4000_0000_0000_0022, Z, 1,
            4'h4, 1, 64'h0000_0000_0000_0021, 1, 2, 0);
        row(0, 4'h0, Z, Z, Z, Z, 1, 4'h0, 1, 64'h4000_0000_0000_0022, 0, 0, 0);
        // protocol error: body flit from req3 while idle is swallowed
        row(0, 4'h8, Z, Z, Z, 64'h0000_0000_0000_0033, 1, 4'h8, 0, Z, 0, 0, 0);
        row(0, 4'h0, Z, Z, Z, Z, 1, 4'h0, 0, Z, 0, 0, 1);
        row(0, 4'h1, 64'hC000_0000_0000_0040, Z, Z, Z, 1, 4'h1, 0, Z, 0, 0, 1);
        row(0, 4'h0, Z, Z, Z, Z, 1, 4'h0, 1, 64'hC000_0000_0000_0040, 0, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].d[0], tbl[i].d[1], tbl[i].d[2],
                  tbl[i].d[3], tbl[i].ordy);
            chk("req_ready", i, 64'(req_ready), 64'(tbl[i].e_ready));
            chk("out_valid", i, 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk("out_data", i, out_data, tbl[i].e_od);
            chk("lock", i, 64'(lock), 64'(tbl[i].e_lock));
            chk("lock_idx", i, 64'(lock_idx), 64'(tbl[i].e_lidx));
            chk("err", i, 64'(err), 64'(tbl[i].e_err));
            $display("row %0d rst=%b valid=%h ready=%h ov=%b od=%h lock=%b idx=%0d err=%b",
                     i, rst, req_valid, req_ready, out_valid, out_data, lock, lock_idx, err);
        end

        // backpressure: 4-flit packet from req1 with the router stalled for 5 cycles
        bp[0] = 64'h8000_0000_0000_0050; bp[1] = 64'h0000_0000_0000_0051;
        bp[2] = 64'h0000_0000_0000_0052; bp[3] = 64'h4000_0000_0000_0053;
        acc = 0; got = 0; cyc = 0;
        while (got < 4 && cyc < 30) begin
            drive(0, (acc < 4) ? 4'h2 : 4'h0, Z, bp[acc % 4], Z, Z, (cyc >= 5));
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_ready_low", cyc, 64'(req_ready), 64'h0);
                chk("bp_accepted", cyc, 64'(acc), 64'd2);
            end
            if (cyc == 3) begin
                chk("bp_lock_idx", cyc, 64'(lock_idx), 64'd1);
                chk("bp_err_sticky", cyc, 64'(err), 64'd1);
            end
            if (out_valid && out_ready) begin
                chk("bp_out_data", got, out_data, bp[got]);
                got++;
            end
            if (req_valid[1] && req_ready[1]) acc++;
            $display("bp cycle %0d accepted=%0d delivered=%0d ready=%h", cyc, acc, got,
                     req_ready);
            cyc++;
        end
        chk("bp_delivered", cyc, 64'(got), 64'd4);
        chk("bp_total_acc", cyc, 64'(acc), 64'd4);

        // reset after 2 of 5 flits of req1; router stalled so both sit in the buffer
        drive(0, 4'h2, Z, 64'h8000_0000_0000_0060, Z, Z, 0);
        chk("mid_ready_head", 0, 64'(req_ready), 64'h2);
        drive(0, 4'h2, Z, 64'h0000_0000_0000_0061, Z, Z, 0);
        chk("mid_lock", 1, 64'(lock), 64'd1);
        chk("mid_lock_idx", 1, 64'(lock_idx), 64'd1);
        drive(1, 4'h2, Z, 64'h0000_0000_0000_0062, Z, Z, 0);
        chk("mid_ready_rst", 2, 64'(req_ready), 64'h0);
        drive(0, 4'h9, 64'hC000_0000_0000_0070, Z, Z, 64'hC000_0000_0000_0073, 1);
        chk("mid_flushed", 3, 64'(out_valid), 64'd0);
        chk("mid_idle", 3, 64'(lock), 64'd0);
        chk("mid_err_clr", 3, 64'(err), 64'd0);
        chk("mid_ptr0", 3, 64'(req_ready), 64'h1);
        drive(0, 4'h8, Z, Z, Z, 64'hC000_0000_0000_0073, 1);
        chk("mid_out0", 4, out_data, 64'hC000_0000_0000_0070);
        chk("mid_next", 4, 64'(req_ready), 64'h8);
        drive(0, 4'h0, Z, Z, Z, Z, 1);
        chk("mid_out3", 5, out_data, 64'hC000_0000_0000_0073);
        $display("reset-mid sequence out=%h ov=%b", out_data, out_valid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
